stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
MEM stage of the 5-stage MIPS pipeline, sitting directly upstream of the write-back stage. It performs byte/half/word loads and stores on an internal data memory, aligns and extends load data, and registers everything the write-back stage consumes into the MEM/WB pipeline register. It also provides a registered debug read port for the debug unit.

Parameters:
DEPTH, 256, data memory size in 32-bit words (power of 2)
ADDR_W, 8, word-address width, equal to log2(DEPTH)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous reset, active-high
i_enable  in  1  pipeline advance (debug unit step/run); low = hold all state
i_ALU_res  in  32  ALU result; byte address for loads/stores
i_write_data  in  32  store data (rt)
i_addr_reg_dst  in  5  destination register
i_pc_to_reg  in  32  return address for jal/jalr
is_MemRead  in  1  load instruction
is_MemWrite  in  1  store instruction
is_mem_size  in  2  00 byte, 01 half, 11 word, 10 treated as word
is_unsigned  in  1  zero-extend loads (LBU/LHU)
is_RegWrite, is_MemtoReg, is_write_pc, is_stop_pipe  in  1 each  control passed to WB
i_debug_addr  in  ADDR_W  debug word address
o_output_mem  out  32  aligned/extended load data (MEM/WB)
o_ALU_res  out  32  registered i_ALU_res
o_addr_reg_dst  out  5  registered destination
o_pc_to_reg  out  32  registered return address
os_RegWrite, os_MemtoReg, os_write_pc, os_stop_pipe  out  1 each  registered controls
os_misaligned  out  1  registered: current MEM access was misaligned
o_debug_data  out  32  registered memory word at i_debug_addr

Behaviour:
- Reset (async, while i_reset=1): every output register = 0. Memory array is not reset; contents undefined until written.
- Latency: 1 cycle. Inputs sampled at edge N with i_enable=1 appear on the MEM/WB outputs after edge N.
- i_enable=0: MEM/WB registers hold their value; no memory write occurs. o_debug_data still updates every cycle.
- Word index = i_ALU_res[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH. Little-endian byte lanes selected by i_ALU_res[1:0].
- Misalignment: half requires addr[0]=0; word requires addr[1:0]=00. Misaligned store: memory is not modified. Misaligned load: o_output_mem=0. os_misaligned=1 for that instruction only, and only when MemRead or MemWrite is set.
- Stores (is_MemWrite & i_enable & aligned): byte writes i_write_data[7:0] into lane addr[1:0]; half writes [15:0] into lanes addr[1]*2 and addr[1]*2+1; word writes the full word. All other lanes are preserved.
- Loads: read the word combinationally, select the lane, then sign-extend, or zero-extend if is_unsigned. Word loads ignore is_unsigned. With MemRead=0, o_output_mem = 0.
- If MemRead and MemWrite are both 1: the write is performed, and load data is the pre-write word.
- Debug port: o_debug_data <= mem[i_debug_addr] every edge. If that address is written on the same edge, the old value is captured.
- Stop: is_stop_pipe is registered like the other controls. It has no effect inside this stage.
- Reset asserted mid-store: that write is not guaranteed to occur. Outputs are 0 immediately (asynchronous).

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF; LW 0x10 with MemtoReg=1 -> o_output_mem=0xDEADBEEF one edge later; os_misaligned=0.
- SB 0x13 data 0x000000AA over 0x11223344, then LW 0x10 -> 0xAA223344. LB 0x13 -> 0xFFFFFFAA. LBU 0x13 -> 0x000000AA.
- SH 0x12 data 0x8001, then LH 0x12 -> 0xFFFF8001 and LHU 0x12 -> 0x00008001. LW 0x10 -> low half unchanged.
- SW 0x06 (misaligned) -> memory at word 1 unchanged, os_misaligned=1. Next instruction (no memory access) -> os_misaligned=0. LH 0x01 -> o_output_mem=0, os_misaligned=1.
- With i_enable=0 for 3 cycles while presenting SW 0x20 -> no write, outputs hold. Raise i_enable -> write lands and outputs advance. Debug read of word 8 -> old value on the write edge, new value on the next edge.
- Pass-through: pc_to_reg=0x40, write_pc=1, RegWrite=1, dst=31, stop_pipe=1 -> all appear unchanged after one edge. Assert i_reset mid-cycle -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/stage_memory.sv
// stage_memory: MIPS MEM stage with byte/half/word data memory and MEM/WB register.
// Latency: 1 cycle from inputs to MEM/WB outputs; debug read port also 1 cycle.
// Backpressure: i_enable=0 freezes MEM/WB and blocks stores; debug port keeps reading.
module stage_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [31:0]       i_ALU_res,
  input  logic [31:0]       i_write_data,
  input  logic [4:0]        i_addr_reg_dst,
  input  logic [31:0]       i_pc_to_reg,
  input  logic              is_MemRead,
  input  logic              is_MemWrite,
  input  logic [1:0]        is_mem_size,
  input  logic              is_unsigned,
  input  logic              is_RegWrite,
  input  logic              is_MemtoReg,
  input  logic              is_write_pc,
  input  logic              is_stop_pipe,
  input  logic [ADDR_W-1:0] i_debug_addr,
  output logic [31:0]       o_output_mem,
  output logic [31:0]       o_ALU_res,
  output logic [4:0]        o_addr_reg_dst,
  output logic [31:0]       o_pc_to_reg,
  output logic              os_RegWrite,
  output logic              os_MemtoReg,
  output logic              os_write_pc,
  output logic              os_stop_pipe,
  output logic              os_misaligned,
  output logic [31:0]       o_debug_data
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Data memory array; deliberately not reset.
  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              sz_byte;
  logic              sz_half;
  logic              sz_word;
  logic              mem_access;
  logic              misaligned;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic [31:0]       wr_repl;
  logic [3:0]        byte_en;
  logic [31:0]       wr_word;
  logic              wr_en;

  // MEM/WB pipeline register next/current state
  logic [31:0] output_mem_d, output_mem_q;
  logic [31:0] alu_res_d, alu_res_q;
  logic [4:0]  reg_dst_d, reg_dst_q;
  logic [31:0] pc_to_reg_d, pc_to_reg_q;
  logic        regwrite_d, regwrite_q;
  logic        memtoreg_d, memtoreg_q;
  logic        write_pc_d, write_pc_q;
  logic        stop_pipe_d, stop_pipe_q;
  logic        misaligned_d, misaligned_q;
  logic [31:0] debug_data_q;

  // Address split and access-size decode; size 2'b10 falls through to word.
  always_comb begin
    word_idx   = i_ALU_res[ADDR_W+1:2];
    lane       = i_ALU_res[1:0];
    sz_byte    = (is_mem_size == SIZE_BYTE);
    sz_half    = (is_mem_size == SIZE_HALF);
    sz_word    = !(sz_byte || sz_half);
    mem_access = is_MemRead || is_MemWrite;
    misaligned = mem_access &&
                 ((sz_half && lane[0]) || (sz_word && (lane != 2'b00)));
  end

  // Asynchronous read of the addressed word (pre-write value on a combined read/write).
  always_comb begin
    rd_word = mem_q[word_idx];
  end

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    if (is_MemRead && !misaligned) begin
      if (sz_byte) begin
        load_data = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end else if (sz_half) begin
        load_data = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end else begin
        load_data = rd_word;
      end
    end
  end

  // Store merge: replicate store data across lanes, then keep unselected lanes.
  always_comb begin
    if (sz_byte) begin
      wr_repl = {4{i_write_data[7:0]}};
      byte_en = 4'b0001 << lane;
    end else if (sz_half) begin
      wr_repl = {2{i_write_data[15:0]}};
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
    end else begin
      wr_repl = i_write_data;
      byte_en = 4'b1111;
    end
    for (int k = 0; k < 4; k++) begin
      wr_word[8*k +: 8] = byte_en[k] ? wr_repl[8*k +: 8] : rd_word[8*k +: 8];
    end
    wr_en = i_enable && is_MemWrite && !misaligned;
  end

  // Memory write port; misaligned or stalled stores leave the array untouched.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  // Next state of MEM/WB: advance on enable, otherwise hold.
  always_comb begin
    output_mem_d = output_mem_q;
    alu_res_d    = alu_res_q;
    reg_dst_d    = reg_dst_q;
    pc_to_reg_d  = pc_to_reg_q;
    regwrite_d   = regwrite_q;
    memtoreg_d   = memtoreg_q;
    write_pc_d   = write_pc_q;
    stop_pipe_d  = stop_pipe_q;
    misaligned_d = misaligned_q;
    if (i_enable) begin
      output_mem_d = load_data;
      alu_res_d    = i_ALU_res;
      reg_dst_d    = i_addr_reg_dst;
      pc_to_reg_d  = i_pc_to_reg;
      regwrite_d   = is_RegWrite;
      memtoreg_d   = is_MemtoReg;
      write_pc_d   = is_write_pc;
      stop_pipe_d  = is_stop_pipe;
      misaligned_d = misaligned;
    end
  end

  // MEM/WB register with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      output_mem_q <= 32'd0;
      alu_res_q    <= 32'd0;
      reg_dst_q    <= 5'd0;
      pc_to_reg_q  <= 32'd0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      write_pc_q   <= 1'b0;
      stop_pipe_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      output_mem_q <= output_mem_d;
      alu_res_q    <= alu_res_d;
      reg_dst_q    <= reg_dst_d;
      pc_to_reg_q  <= pc_to_reg_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      write_pc_q   <= write_pc_d;
      stop_pipe_q  <= stop_pipe_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Debug read port samples every edge regardless of enable; same-edge writes show next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      debug_data_q <= 32'd0;
    end else begin
      debug_data_q <= mem_q[i_debug_addr];
    end
  end

  assign o_output_mem   = output_mem_q;
  assign o_ALU_res      = alu_res_q;
  assign o_addr_reg_dst = reg_dst_q;
  assign o_pc_to_reg    = pc_to_reg_q;
  assign os_RegWrite    = regwrite_q;
  assign os_MemtoReg    = memtoreg_q;
  assign os_write_pc    = write_pc_q;
  assign os_stop_pipe   = stop_pipe_q;
  assign os_misaligned  = misaligned_q;
  assign o_debug_data   = debug_data_q;

endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: directed stimulus for stage_memory with a byte-addressed reference model.
// Latency: model predicts outputs one edge after inputs are applied.
// Backpressure: exercises i_enable stalls and mid-cycle asynchronous reset.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] alu = '0, wd = '0, pc = '0;
  logic [4:0]  dst = '0;
  logic        rd = 1'b0, wr = 1'b0, uns = 1'b0;
  logic [1:0]  sz = 2'b11;
  logic        regw = 1'b0, m2r = 1'b0, wpc = 1'b0, stop = 1'b0;
  logic [7:0]  dbg_addr = '0;

  logic [31:0] out_mem, out_alu, out_pc, out_dbg;
  logic [4:0]  out_dst;
  logic        out_regw, out_m2r, out_wpc, out_stop, out_mis;

  logic [31:0] e_mem, e_alu, e_pc, e_dbg;
  logic [4:0]  e_dst;
  logic        e_regw, e_m2r, e_wpc, e_stop, e_mis;

  logic [7:0]  mem_b [1024];
  int          checks = 0;
  int          errors = 0;
  logic        check_en = 1'b0;

  stage_memory #(.DEPTH(256), .ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
    .i_ALU_res(alu), .i_write_data(wd), .i_addr_reg_dst(dst), .i_pc_to_reg(pc),
    .is_MemRead(rd), .is_MemWrite(wr), .is_mem_size(sz), .is_unsigned(uns),
    .is_RegWrite(regw), .is_MemtoReg(m2r), .is_write_pc(wpc), .is_stop_pipe(stop),
    .i_debug_addr(dbg_addr),
    .o_output_mem(out_mem), .o_ALU_res(out_alu), .o_addr_reg_dst(out_dst),
    .o_pc_to_reg(out_pc), .os_RegWrite(out_regw), .os_MemtoReg(out_m2r),
    .os_write_pc(out_wpc), .os_stop_pipe(out_stop), .os_misaligned(out_mis),
    .o_debug_data(out_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_b[(a + k) % 1024];
    return w;
  endfunction

  // Reference model: memory is a flat byte array, accesses are n consecutive little-endian bytes.
  always @(posedge clk or posedge rst) begin : model
    int n;
    int a;
    logic [31:0] v;
    logic [31:0] tmp;
    logic bad;
    if (rst) begin
      e_mem = 0; e_alu = 0; e_pc = 0; e_dbg = 0; e_dst = 0;
      e_regw = 0; e_m2r = 0; e_wpc = 0; e_stop = 0; e_mis = 0;
    end else begin
      e_dbg = word_at(int'(dbg_addr) * 4);
      if (en) begin
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a   = int'(alu % 32'd1024);
        bad = (rd || wr) && (a % n != 0);
        v   = 0;
        if (rd && !bad) begin
          for (int k = 0; k < n; k++) v = v | (32'(mem_b[(a + k) % 1024]) << (8 * k));
          if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        end
        if (wr && !bad) begin
          for (int k = 0; k < n; k++) begin
            tmp = wd >> (8 * k);
            mem_b[(a + k) % 1024] = tmp[7:0];
          end
        end
        e_mem = v; e_alu = alu; e_pc = pc; e_dst = dst; e_mis = bad;
        e_regw = regw; e_m2r = m2r; e_wpc = wpc; e_stop = stop;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("mdl_output_mem", out_mem, e_mem);
      chk("mdl_alu_res", out_alu, e_alu);
      chk("mdl_reg_dst", 32'(out_dst), 32'(e_dst));
      chk("mdl_pc_to_reg", out_pc, e_pc);
      chk("mdl_ctrl", {28'd0, out_regw, out_m2r, out_wpc, out_stop},
                      {28'd0, e_regw, e_m2r, e_wpc, e_stop});
      chk("mdl_misaligned", 32'(out_mis), 32'(e_mis));
      chk("mdl_debug", out_dbg, e_dbg);
    end
  end

  task automatic drive(input logic e, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic [4:0] ds, input logic rw,
                       input logic mr, input logic wp, input logic st);
    @(negedge clk);
    en = e; rd = r; wr = w; sz = s; uns = u; alu = a; wd = d;
    pc = p; dst = ds; regw = rw; m2r = mr; wpc = wp; stop = st;
    @(posedge clk);
    #1;
  endtask

  task automatic mop(input logic r, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, r, w, s, u, a, d, 32'd0, 5'd0, 1'b0, r, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_output_mem", out_mem, 32'd0);
    chk("rst_alu_res", out_alu, 32'd0);
    chk("rst_pc_to_reg", out_pc, 32'd0);
    chk("rst_misc", {out_dst, out_regw, out_m2r, out_wpc, out_stop, out_mis}, 32'd0);
    chk("rst_debug", out_dbg, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bring every word to a known value so the model is exact everywhere.
    for (int i = 0; i < 256; i++) mop(1'b0, 1'b1, 2'b11, 1'b0, 32'(i * 4), 32'd0);
    mop(1'b0, 1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
    check_en = 1'b1;

    // Word store and load
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    chk("lw_deadbeef", out_mem, 32'hDEADBEEF);
    chk("lw_aligned", 32'(out_mis), 32'd0);
    chk("lw_memtoreg", 32'(out_m2r), 32'd1);

    // Byte store into lane 3, signed/unsigned byte loads
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h11223344);
    mop(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA);
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    chk("sb_lane3_word", out_mem, 32'hAA223344);
    mop(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    chk("lb_signed", out_mem, 32'hFFFFFFAA);
    mop(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    chk("lbu", out_mem, 32'h000000AA);

    // Half store into upper half, signed/unsigned half loads
    mop(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
    mop(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    chk("lh_signed", out_mem, 32'hFFFF8001);
    mop(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
    chk("lhu", out_mem, 32'h00008001);
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    chk("sh_low_half_kept", out_mem, 32'h80013344);

    // Misaligned accesses
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF);
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h12345678);
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h06, 32'hCAFEF00D);
    chk("sw_misaligned_flag", 32'(out_mis), 32'd1);
    mop(1'b0, 1'b0, 2'b11, 1'b0, 32'h07, 32'd0);
    chk("no_access_not_misaligned", 32'(out_mis), 32'd0);
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h04, 32'd0);
    chk("sw_misaligned_no_write", out_mem, 32'h12345678);
    mop(1'b1, 1'b0, 2'b01, 1'b0, 32'h01, 32'd0);
    chk("lh_misaligned_data", out_mem, 32'd0);
    chk("lh_misaligned_flag", 32'(out_mis), 32'd1);

    // Size code 10 acts as word; addresses wrap modulo 1024 bytes
    mop(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
    chk("size10_word", out_mem, 32'h12345678);
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h404, 32'd0);
    chk("addr_wrap", out_mem, 32'h12345678);

    // Simultaneous read and write: load returns the pre-write word
    mop(1'b1, 1'b1, 2'b11, 1'b0, 32'h04, 32'hAAAA5555);
    chk("rw_pre_write", out_mem, 32'h12345678);
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h04, 32'd0);
    chk("rw_post_write", out_mem, 32'hAAAA5555);

    // Enable stall with a pending store to word 8, observed through the debug port
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h00001111);
    dbg_addr = 8'd8;
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h00002222,
            32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_hold_alu", out_alu, 32'h10);
      chk("stall_hold_mem", out_mem, 32'h80013344);
      chk("stall_no_write_dbg", out_dbg, 32'h00001111);
    end
    mop(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h00002222);
    chk("resume_alu", out_alu, 32'h20);
    chk("dbg_old_on_write_edge", out_dbg, 32'h00001111);
    mop(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
    chk("dbg_new_next_edge", out_dbg, 32'h00002222);

    // Control pass-through
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h5, 32'd0,
          32'h40, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("pass_pc", out_pc, 32'h40);
    chk("pass_dst", 32'(out_dst), 32'd31);
    chk("pass_ctrl", {28'd0, out_regw, out_m2r, out_wpc, out_stop}, 32'h0000000B);

    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", out_pc, 32'd0);
    chk("async_rst_alu", out_alu, 32'd0);
    chk("async_rst_misc", {out_dst, out_regw, out_m2r, out_wpc, out_stop, out_mis}, 32'd0);
    chk("async_rst_debug", out_dbg, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mop(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    chk("mem_survives_reset", out_mem, 32'h80013344);

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
